// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Brief    : Shared types and defaults for the two-requester memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int unsigned c_default_addr_w = 32;
    localparam int unsigned c_default_data_w = 32;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IF   = 2'd1,
        OWNER_DATA = 2'd2
    } owner_e;

    // Encoding of the last-winner bit fed to the pick logic
    localparam logic c_winner_if   = 1'b0;
    localparam logic c_winner_data = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pick
// Brief    : Combinational grant decision between fetch and load/store ports.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_winner,
    output logic i_gnt,
    output logic d_gnt
);

    logic w_tie_to_d;

    // On a tie the port that lost the previous tie takes this one
    assign w_tie_to_d = (last_winner == c_winner_if);

    assign d_gnt = d_req & (~i_req | w_tie_to_d);
    assign i_gnt = i_req & (~d_req | ~w_tie_to_d);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Arbitrates an instruction-fetch port and a load/store port onto
//            one single-port, 1-cycle-latency memory. Define MEM_ARBITER_RR_EN
//            for round-robin on ties; otherwise the data port always wins.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = c_default_addr_w,
    parameter int unsigned DATA_W = c_default_data_w
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,

    output logic                  mem_en,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam logic [ADDR_W-1:0] c_word_mask = {{(ADDR_W-2){1'b1}}, 2'b00};

    owner_e              r_owner;
    owner_e              w_owner_nxt;
    logic                w_last_winner;
    logic                w_pick_i;
    logic                w_pick_d;
    logic [ADDR_W-1:0]   w_addr_sel;

    mem_arb_pick u_pick (
        .i_req       (i_req),
        .d_req       (d_req),
        .last_winner (w_last_winner),
        .i_gnt       (w_pick_i),
        .d_gnt       (w_pick_d)
    );

`ifdef MEM_ARBITER_RR_EN
    logic r_last_winner;

    // Only contested cycles move the round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_winner <= c_winner_if;
        end else if (i_req && d_req) begin
            r_last_winner <= w_pick_d ? c_winner_data : c_winner_if;
        end
    end

    assign w_last_winner = r_last_winner;
`else
    assign w_last_winner = c_winner_if;
`endif

    // Flops are held by the async reset, so only the visible grants need gating
    assign i_gnt  = w_pick_i & rst_n;
    assign d_gnt  = w_pick_d & rst_n;
    assign mem_en = i_gnt | d_gnt;

    always_comb begin
        w_addr_sel = '0;
        mem_wdata  = '0;
        mem_we     = '0;
        if (d_gnt) begin
            w_addr_sel = d_addr;
            mem_wdata  = d_wdata;
            if (d_we) begin
                mem_we = d_be;
            end
        end else if (i_gnt) begin
            w_addr_sel = i_addr;
        end
    end

    assign mem_addr = w_addr_sel & c_word_mask;

    // Response-owner state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= OWNER_NONE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    always_comb begin
        w_owner_nxt = OWNER_NONE;
        if (w_pick_d) begin
            w_owner_nxt = OWNER_DATA;
        end else if (w_pick_i) begin
            w_owner_nxt = OWNER_IF;
        end
    end

    always_comb begin
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        i_rdata  = '0;
        d_rdata  = '0;
        case (r_owner)
            OWNER_IF: begin
                i_rvalid = 1'b1;
                i_rdata  = mem_rdata;
            end
            OWNER_DATA: begin
                d_rvalid = 1'b1;
                d_rdata  = mem_rdata;
            end
            default: ;
        endcase
    end

`ifndef SYNTHESIS
    a_one_hot_gnt: assert property (@(posedge clk) disable iff (!rst_n) !(i_gnt && d_gnt));
    a_gnt_needs_req: assert property (@(posedge clk) disable iff (!rst_n)
        (!i_gnt || i_req) && (!d_gnt || d_req));
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench for mem_arbiter: directed scenarios, then random
//            traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata = '0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int unsigned cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Environment memory (what the DUT talks to) and the model's view of it
    logic [31:0] mem_arr [256];
    logic [31:0] ref_mem [256];
    logic [7:0]  env_idx;

    assign env_idx = 8'(mem_addr >> 2);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) begin
            mem_rdata <= mem_arr[env_idx];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem_arr[env_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    typedef struct {
        int unsigned cyc;
        bit          is_d;
        bit          is_write;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: decide the winner from the arbitration rules, check the
    // memory-side request, and queue the response expected one cycle later.
    bit          m_last_tie_d;
    bit          m_ei, m_ed;
    logic [7:0]  m_idx;
    exp_t        m_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_i_gnt", i_gnt, 0);
            chk("rst_d_gnt", d_gnt, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_we", mem_we, 0);
            m_last_tie_d = 1'b0;
        end else begin
            m_ei = i_req && !d_req;
            m_ed = d_req && !i_req;
            if (i_req && d_req) begin
`ifdef MEM_ARBITER_RR_EN
                m_ed = !m_last_tie_d;
`else
                m_ed = 1'b1;
`endif
                m_ei = !m_ed;
                m_last_tie_d = m_ed;
            end
            chk("i_gnt", i_gnt, m_ei);
            chk("d_gnt", d_gnt, m_ed);
            chk("mem_en", mem_en, m_ei | m_ed);
            if (m_ei || m_ed) begin
                m_e.cyc      = cyc;
                m_e.is_d     = m_ed;
                m_e.is_write = m_ed && d_we;
                if (m_ed) begin
                    chk("mem_addr_d", mem_addr, {d_addr[31:2], 2'b00});
                    chk("mem_we_d", mem_we, d_we ? d_be : 4'h0);
                    m_idx = d_addr[9:2];
                end else begin
                    chk("mem_addr_i", mem_addr, {i_addr[31:2], 2'b00});
                    chk("mem_we_i", mem_we, 4'h0);
                    m_idx = i_addr[9:2];
                end
                m_e.data = ref_mem[m_idx];
                if (m_e.is_write) begin
                    chk("mem_wdata", mem_wdata, d_wdata);
                    for (int b = 0; b < 4; b++)
                        if (d_be[b]) ref_mem[m_idx][8*b +: 8] = d_wdata[8*b +: 8];
                end
                exp_q.push_back(m_e);
            end else begin
                chk("mem_we_idle", mem_we, 4'h0);
            end
        end
    end

    // Monitor: compare response ports against the queued expectations
    exp_t mon_e;
    bit   mon_have;

    always begin
        @(posedge clk);
        #3;
        if (!rst_n) begin
            exp_q.delete();
            chk("rst_i_rvalid", i_rvalid, 0);
            chk("rst_d_rvalid", d_rvalid, 0);
            chk("rst_i_rdata", i_rdata, 0);
            chk("rst_d_rdata", d_rdata, 0);
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc + 1 < cyc) begin
                chk("stale_response", 0, 1);
                void'(exp_q.pop_front());
            end
            mon_have = (exp_q.size() > 0) && (exp_q[0].cyc + 1 == cyc);
            if (mon_have) mon_e = exp_q.pop_front();
            chk("i_rvalid", i_rvalid, mon_have && !mon_e.is_d);
            chk("d_rvalid", d_rvalid, mon_have && mon_e.is_d);
            if (mon_have && !mon_e.is_write) begin
                if (mon_e.is_d) chk("d_rdata", d_rdata, mon_e.data);
                else            chk("i_rdata", i_rdata, mon_e.data);
            end
            if (!(mon_have && mon_e.is_d))  chk("d_rdata_idle", d_rdata, 0);
            if (!(mon_have && !mon_e.is_d)) chk("i_rdata_idle", i_rdata, 0);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic i_fetch(input logic [31:0] a);
        int n = 0;
        i_req  = 1'b1;
        i_addr = a;
        @(negedge clk);
        while (!i_gnt && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("i_fetch_gnt", i_gnt, 1);
        next_cycle();
        i_req = 1'b0;
    endtask

    task automatic d_access(input logic we, input logic [3:0] be, input logic [31:0] a,
                            input logic [31:0] wd);
        int n = 0;
        d_req   = 1'b1;
        d_we    = we;
        d_be    = be;
        d_addr  = a;
        d_wdata = wd;
        @(negedge clk);
        while (!d_gnt && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("d_access_gnt", d_gnt, 1);
        next_cycle();
        d_req = 1'b0;
    endtask

`ifdef MEM_ARBITER_RR_EN
    logic [3:0] tie_pat = 4'b0101;
`else
    logic [3:0] tie_pat = 4'b1111;
`endif

    bit i_pend, d_pend;

    initial begin
        for (int k = 0; k < 256; k++) begin
            mem_arr[k] = $urandom;
            ref_mem[k] = mem_arr[k];
        end
        mem_arr[0] = 32'h0000_0013; ref_mem[0] = 32'h0000_0013;
        mem_arr[1] = 32'h0000_0013; ref_mem[1] = 32'h0000_0013;
        mem_arr[2] = 32'h0340_0093; ref_mem[2] = 32'h0340_0093;

        // Reset with both requests raised: nothing may be granted
        rst_n = 1'b0;
        i_req = 1'b1; i_addr = 32'h4;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h8; d_wdata = 32'h1234_5678;
        repeat (3) next_cycle();
        rst_n = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        next_cycle();
        rst_n = 1'b1;

        // Single fetch, then three back-to-back fetches
        i_fetch(32'h8);
        next_cycle();
        i_fetch(32'h0);
        i_fetch(32'h4);
        i_fetch(32'h8);
        next_cycle();

        // Word write then read-back, then a byte read at an unaligned address
        d_access(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        d_access(1'b0, 4'hF, 32'h10, 32'h0);
        d_access(1'b0, 4'h1, 32'h13, 32'h0);
        next_cycle();

        // Contended requests held for four cycles
        i_req = 1'b1; i_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h40;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("tie_d_gnt", d_gnt, tie_pat[k]);
            chk("tie_i_gnt", i_gnt, !tie_pat[k]);
            next_cycle();
            if (tie_pat[k]) d_addr = d_addr + 4;
            else            i_addr = i_addr + 4;
        end
        i_req = 1'b0; d_req = 1'b0;
        next_cycle();

        // Reset lands in the cycle after a data grant
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24;
        @(negedge clk);
        chk("pre_rst_d_gnt", d_gnt, 1);
        next_cycle();
        rst_n = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        chk("rst_drop_d_rvalid", d_rvalid, 0);
        chk("rst_drop_mem_en", mem_en, 0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        i_req = 1'b1; i_addr = 32'h4;
        @(negedge clk);
        chk("post_rst_i_gnt", i_gnt, 1);
        next_cycle();
        i_req = 1'b0;
        next_cycle();

        // Random traffic; each requester holds its request until granted
        i_pend = 1'b0; d_pend = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!i_pend && $urandom_range(0, 99) < 55) begin
                i_pend = 1'b1;
                i_addr = $urandom_range(0, 1023);
            end
            if (!d_pend && $urandom_range(0, 99) < 55) begin
                d_pend  = 1'b1;
                d_we    = $urandom_range(0, 1);
                d_be    = 4'($urandom_range(0, 15));
                d_addr  = $urandom_range(0, 1023);
                d_wdata = $urandom;
            end
            i_req = i_pend;
            d_req = d_pend;
            @(negedge clk);
            if (i_gnt) i_pend = 1'b0;
            if (d_gnt) d_pend = 1'b0;
            next_cycle();
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (3) next_cycle();
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, giving the byte-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the memory word width; the byte-enable width is DATA_W/8.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  is the asynchronous, active-low reset.
REQ-005 Ports i_req in 1, i_addr in ADDR_W, i_gnt out 1, i_rvalid out 1, i_rdata out DATA_W SHALL form the instruction-fetch (read-only) requester.
REQ-006 Ports d_req in 1, d_we in 1, d_be in DATA_W/8, d_addr in ADDR_W, d_wdata in DATA_W, d_gnt out 1, d_rvalid out 1, d_rdata out DATA_W SHALL form the load/store requester.
REQ-007 Ports mem_en out 1, mem_we out DATA_W/8, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W SHALL drive one single-port memory with 1-cycle read latency.

Function
REQ-008 In any cycle with rst_n high, at most one of i_gnt, d_gnt SHALL be 1; a grant SHALL never be given without the matching req.
REQ-009 Grants SHALL be combinational from the req inputs and the registered arbitration state, in the same cycle as the request.
REQ-010 mem_en SHALL equal i_gnt | d_gnt; mem_addr, mem_wdata, mem_we SHALL come from the granted port in that cycle, with mem_addr[1:0] forced to 0.
REQ-011 mem_we SHALL be d_be when d_gnt & d_we, else all zero; instruction grants SHALL never write.
REQ-012 A response-owner register SHALL have states NONE, IF, DATA; next state SHALL be IF on i_gnt, DATA on d_gnt, else NONE.
REQ-013 i_rvalid SHALL be 1 exactly when owner==IF; d_rvalid SHALL be 1 exactly when owner==DATA; both SHALL be 0 when owner==NONE.
REQ-014 Latency: a request granted in cycle N SHALL produce its rvalid in cycle N+1; writes SHALL also get an rvalid pulse as the completion acknowledgement.
REQ-015 i_rdata/d_rdata SHALL equal mem_rdata while the matching rvalid is 1, else all zero.
REQ-016 Back-to-back grants in consecutive cycles SHALL be supported, one access per cycle, with no idle cycle inserted.
REQ-017 A requester SHALL hold req and its address/data stable until it sees gnt; the arbiter SHALL not buffer ungranted requests.
REQ-018 Default arbitration (macro undefined): d_req SHALL always win over i_req when both are 1.

Reset
REQ-019 While rst_n is 0: owner=NONE, last-winner=IF, i_gnt=d_gnt=0, mem_en=0, mem_we=0, both rvalid=0, both rdata=0, regardless of req inputs.
REQ-020 Reset asserted in the cycle after a grant SHALL suppress that rvalid; the access SHALL be lost and not replayed.
REQ-021 The first cycle after rst_n rises SHALL allow grants normally.

Configuration
REQ-022 When MEM_ARBITER_RR_EN is defined, simultaneous requests SHALL alternate: the port not granted in the most recent simultaneous-request cycle wins; the last-winner register SHALL update only in cycles where both req are 1.
REQ-023 When MEM_ARBITER_RR_EN is undefined, the last-winner register SHALL not exist, and REQ-018 fixed priority SHALL apply.

Structure
REQ-024 A shared package SHALL hold the owner-state enum (NONE, IF, DATA) and the default ADDR_W/DATA_W constants.
REQ-025 Arbitration decision logic SHALL be one sub-module, mem_arb_pick (inputs: i_req, d_req, last-winner; outputs: i_gnt, d_gnt); the rest SHALL stay in mem_arbiter.

Verification
REQ-026 i_req=1, i_addr=0x8, d_req=0; mem[2]=0x03400093 -> i_gnt=1 same cycle, next cycle i_rvalid=1, i_rdata=0x03400093, d_rvalid=0.
REQ-027 d_req=1, d_we=1, d_be=0xF, d_addr=0x10, d_wdata=0xDEADBEEF, then d read of 0x10 -> write ack d_rvalid=1, then d_rdata=0xDEADBEEF.
REQ-028 i_req=d_req=1 held 4 cycles, macro undefined -> d_gnt=1 all 4 cycles, i_gnt=0; with MEM_ARBITER_RR_EN -> grants D,I,D,I (first winner D since last-winner resets to IF).
REQ-029 i_req held 3 cycles at 0x0,0x4,0x8 (nops 0x00000013, addi 0x03400093) -> three i_gnt, i_rvalid 3 consecutive cycles with data in order.
REQ-030 d_req granted in cycle N, rst_n=0 in cycle N+1 -> d_rvalid=0, mem_en=0; after release, new i_req granted in first cycle.
REQ-031 d_addr=0x13, byte read -> mem_addr=0x10, mem_we=0.
